rvfpm_result_fifo: RTL and testbench

Result-side buffer between the rvfpm coprocessor and the core's XIF result channel. It accepts completed results (id, data, rd, we, exc) from the FPU via valid/ready. It holds up to DEPTH of them in order and replays them to the core via valid/ready. The FPU can therefore retire results while the core stalls `result_ready`, and `result_valid` stays stable per the XIF rules.

---
 rtl/rvfpm_result_fifo.sv | 159 +++++++++++++++
 tb/tb_rvfpm_result_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_result_fifo.sv
// Result buffer between the rvfpm FPU and the core's XIF result channel: an in-order circular FIFO of DEPTH entries.
// Optional zero-latency pass-through when empty is enabled by defining RVFPM_RESULT_BYPASS_EN.

`ifndef X_ID_WIDTH
`define X_ID_WIDTH 4
`endif
`ifndef FLEN
`define FLEN 32
`endif

module rvfpm_result_fifo #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = `X_ID_WIDTH,
    parameter int FLEN       = `FLEN,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X_ID_WIDTH-1:0] in_id,
    input  logic [FLEN-1:0]       in_data,
    input  logic [4:0]            in_rd,
    input  logic                  in_we,
    input  logic                  in_exc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [X_ID_WIDTH-1:0] out_id,
    output logic [FLEN-1:0]       out_data,
    output logic [4:0]            out_rd,
    output logic                  out_we,
    output logic                  out_exc,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Modulo-DEPTH increment; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [X_ID_WIDTH-1:0] id_mem_r   [DEPTH];
    logic [FLEN-1:0]       data_mem_r [DEPTH];
    logic [4:0]            rd_mem_r   [DEPTH];
    logic                  we_mem_r   [DEPTH];
    logic                  exc_mem_r  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  in_ready_s;
    logic                  push_s;
    logic                  store_s;
    logic                  pop_s;
    logic                  out_valid_s;
    logic [X_ID_WIDTH-1:0] out_id_s;
    logic [FLEN-1:0]       out_data_s;
    logic [4:0]            out_rd_s;
    logic                  out_we_s;
    logic                  out_exc_s;

    // Handshake decode and head-entry output selection.
    always_comb begin
        empty_s     = (count_r == CNT_W'(0));
        full_s      = (count_r == CNT_W'(DEPTH));
        // in_ready deliberately ignores out_ready so bypass cannot form a loop.
        in_ready_s  = !rst && !full_s;
        push_s      = in_valid && in_ready_s;
        pop_s       = out_ready && !empty_s;
        out_id_s    = id_mem_r[rd_ptr_r];
        out_data_s  = data_mem_r[rd_ptr_r];
        out_rd_s    = rd_mem_r[rd_ptr_r];
        out_we_s    = we_mem_r[rd_ptr_r];
        out_exc_s   = exc_mem_r[rd_ptr_r];
`ifdef RVFPM_RESULT_BYPASS_EN
        out_valid_s = !empty_s || push_s;
        store_s     = push_s && !(empty_s && out_ready);
        if (empty_s) begin
            out_id_s   = in_id;
            out_data_s = in_data;
            out_rd_s   = in_rd;
            out_we_s   = in_we;
            out_exc_s  = in_exc;
        end else begin
            out_id_s   = id_mem_r[rd_ptr_r];
            out_data_s = data_mem_r[rd_ptr_r];
            out_rd_s   = rd_mem_r[rd_ptr_r];
            out_we_s   = we_mem_r[rd_ptr_r];
            out_exc_s  = exc_mem_r[rd_ptr_r];
        end
`else
        out_valid_s = !empty_s;
        store_s     = push_s;
`endif
    end

    // Entry storage; data path needs no reset since count gates visibility.
    always_ff @(posedge ck) begin
        if (store_s && !flush) begin
            id_mem_r[wr_ptr_r]   <= in_id;
            data_mem_r[wr_ptr_r] <= in_data;
            rd_mem_r[wr_ptr_r]   <= in_rd;
            we_mem_r[wr_ptr_r]   <= in_we;
            exc_mem_r[wr_ptr_r]  <= in_exc;
        end else begin
            id_mem_r[wr_ptr_r]   <= id_mem_r[wr_ptr_r];
            data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
            rd_mem_r[wr_ptr_r]   <= rd_mem_r[wr_ptr_r];
            we_mem_r[wr_ptr_r]   <= we_mem_r[wr_ptr_r];
            exc_mem_r[wr_ptr_r]  <= exc_mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy update; reset and flush both empty the buffer.
    always_ff @(posedge ck) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (store_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({store_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_id    = out_id_s;
    assign out_data  = out_data_s;
    assign out_rd    = out_rd_s;
    assign out_we    = out_we_s;
    assign out_exc   = out_exc_s;
    assign count     = count_r;

endmodule

// File: tb/tb_rvfpm_result_fifo.sv
// Directed, table-driven bench for rvfpm_result_fifo (default build, DEPTH=4, 4-bit ids, 32-bit data).

module tb_rvfpm_result_fifo;

    logic        ck;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_id;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        in_exc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_exc;
    logic [2:0]  count;

    rvfpm_result_fifo #(.DEPTH(4), .X_ID_WIDTH(4), .FLEN(32)) dut (
        .ck(ck), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_data(in_data),
        .in_rd(in_rd), .in_we(in_we), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
        .out_rd(out_rd), .out_we(out_we), .out_exc(out_exc), .count(count)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic       fl;
        logic       iv;
        logic [3:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_id;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] data_of(input logic [3:0] id);
        return {16'hC0DE, 4'h0, id, 4'h5, ~id};
    endfunction

    function automatic logic [4:0] rd_of(input logic [3:0] id);
        return {1'b0, id} + 5'd8;
    endfunction

    function automatic vec_t mk(input logic fl, input logic iv, input logic [3:0] id, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic [3:0] e_id,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_id = e_id; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [3:0] id, input logic [31:0] data,
                         input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_id     = id;
        in_data   = data;
        in_rd     = rd_of(id);
        in_we     = id[0];
        in_exc    = id[1];
        out_ready = ordy;
    endtask

    task automatic chk_out(input string tag, input logic e_ir, input logic e_ov, input logic [3:0] e_id,
                           input logic [2:0] e_cnt);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(e_ir));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, ".count"}, 64'(count), 64'(e_cnt));
        if (e_ov) begin
            chk({tag, ".out_id"}, 64'(out_id), 64'(e_id));
            chk({tag, ".out_data"}, 64'(out_data), 64'(data_of(e_id)));
            chk({tag, ".out_rd"}, 64'(out_rd), 64'(rd_of(e_id)));
            chk({tag, ".out_we"}, 64'(out_we), 64'(e_id[0]));
            chk({tag, ".out_exc"}, 64'(out_exc), 64'(e_id[1]));
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);

        // Fill to DEPTH, refuse a 5th, then drain in order.
        vecs.push_back(mk(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 4'd1, 3'd1));
        vecs.push_back(mk(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 4'd1, 3'd2));
        vecs.push_back(mk(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 4'd1, 3'd3));
        vecs.push_back(mk(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd1, 3'd4));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 3'd4));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd2, 3'd3));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd3, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd4, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
        // Full with simultaneous pop: push refused that edge, accepted the next.
        vecs.push_back(mk(1'b0, 1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b1, 4'd10, 3'd1));
        vecs.push_back(mk(1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b1, 4'd10, 3'd2));
        vecs.push_back(mk(1'b0, 1'b1, 4'd13, 1'b0, 1'b1, 1'b1, 4'd10, 3'd3));
        vecs.push_back(mk(1'b0, 1'b1, 4'd14, 1'b1, 1'b0, 1'b1, 4'd10, 3'd4));
        vecs.push_back(mk(1'b0, 1'b1, 4'd14, 1'b0, 1'b1, 1'b1, 4'd11, 3'd3));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd11, 3'd4));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd12, 3'd3));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd13, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd14, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
        // Flush with a concurrent push: id 8 must never appear; id 9 becomes head.
        vecs.push_back(mk(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 4'd5, 3'd1));
        vecs.push_back(mk(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 4'd5, 3'd2));
        vecs.push_back(mk(1'b1, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 4'd5, 3'd3));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd9, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));

        // Reset: two cycles high, in_ready low throughout, then idle.
        @(negedge ck); #1;
        chk_out("rst0", 1'b0, 1'b0, 4'd0, 3'd0);
        @(negedge ck); #1;
        chk_out("rst1", 1'b0, 1'b0, 4'd0, 3'd0);
        @(negedge ck);
        rst = 1'b0;
        #1;
        chk_out("idle", 1'b1, 1'b0, 4'd0, 3'd0);

        foreach (vecs[i]) begin
            @(negedge ck);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].id, data_of(vecs[i].id), vecs[i].ordy);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_id, vecs[i].e_cnt);
        end

        // Sustained push+pop of 20 results: head lags input by one, count holds at 1.
        for (int k = 0; k < 20; k++) begin
            @(negedge ck);
            drive(1'b0, 1'b1, 4'(k % 16), data_of(4'(k % 16)), 1'b1);
            #1;
            chk_out($sformatf("wrap%0d", k), 1'b1, (k > 0), 4'((k + 15) % 16), (k > 0) ? 3'd1 : 3'd0);
        end
        @(negedge ck);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        #1;
        chk_out("wrap_last", 1'b1, 1'b1, 4'd3, 3'd1);
        @(negedge ck);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        chk_out("wrap_empty", 1'b1, 1'b0, 4'd0, 3'd0);

        // One-cycle latency without bypass: not visible in the push cycle.
        @(negedge ck);
        drive(1'b0, 1'b1, 4'd7, 32'h3F80_0000, 1'b1);
        #1;
        chk("lat.out_valid_same", 64'(out_valid), 64'd0);
        chk("lat.count_same", 64'(count), 64'd0);
        @(negedge ck);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        #1;
        chk("lat.out_valid_next", 64'(out_valid), 64'd1);
        chk("lat.out_id_next", 64'(out_id), 64'd7);
        chk("lat.out_data_next", 64'(out_data), 64'h3F80_0000);
        chk("lat.count_next", 64'(count), 64'd1);
        @(negedge ck);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        chk_out("lat_empty", 1'b1, 1'b0, 4'd0, 3'd0);

        // Reset mid-operation drops stored entries.
        @(negedge ck);
        drive(1'b0, 1'b1, 4'd1, data_of(4'd1), 1'b0);
        @(negedge ck);
        drive(1'b0, 1'b1, 4'd2, data_of(4'd2), 1'b0);
        @(negedge ck);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("mrst_during", 1'b0, 1'b1, 4'd1, 3'd2);
        @(negedge ck);
        rst = 1'b0;
        #1;
        chk_out("mrst_after", 1'b1, 1'b0, 4'd0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
